// File: rtl/timer_digit_entry.sv
// timer_digit_entry: button-driven front end for a two-digit BCD countdown
// timer. The user edits tens/ones digits, commits, and the block issues an
// active-low reconfigure strobe, arms the one-second enable and then waits
// for the timer's timeout flag.
module timer_digit_entry #(
  parameter int RECONF_CYCLES = 2,
  parameter int MAX_TEN       = 9,
  parameter int MAX_ONE       = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnSelect,
  input  logic       btnCommit,
  input  logic       timeOut,
  output logic [3:0] userDigitTEN,
  output logic [3:0] userDigitONE,
  output logic       timerReconfigTEN_ONE,
  output logic       enable,
  output logic       editSel,
  output logic       armed,
  output logic       expired
);

  localparam logic [1:0] EDIT    = 2'd0;
  localparam logic [1:0] RECONF  = 2'd1;
  localparam logic [1:0] ARMED   = 2'd2;
  localparam logic [1:0] EXPIRED = 2'd3;

  localparam logic [3:0] MAX_TEN_L = 4'(MAX_TEN);
  localparam logic [3:0] MAX_ONE_L = 4'(MAX_ONE);
  localparam logic [3:0] RECONF_L  = 4'(RECONF_CYCLES);

  logic [1:0] state;
  logic [3:0] reconfCnt;
  logic [3:0] editTen;
  logic [3:0] editOne;
  logic       stepUp;
  logic       stepDown;
  logic       digitsNonZero;

  // Wrapping BCD increment; anything at or above the limit folds back to 0,
  // so a digit can never escape its legal range.
  function automatic logic [3:0] incDigit(input logic [3:0] d, input logic [3:0] maxV);
    if (d >= maxV) begin
      return 4'd0;
    end
    return d + 4'd1;
  endfunction

  // Wrapping BCD decrement; 0 (or an out-of-range value) lands on the limit.
  function automatic logic [3:0] decDigit(input logic [3:0] d, input logic [3:0] maxV);
    if (d == 4'd0 || d > maxV) begin
      return maxV;
    end
    return d - 4'd1;
  endfunction

  // Candidate digit values for an edit cycle; up and down together cancel,
  // and only the currently selected digit moves.
  always_comb begin
    stepUp        = btnUp & ~btnDown;
    stepDown      = btnDown & ~btnUp;
    editTen       = userDigitTEN;
    editOne       = userDigitONE;
    digitsNonZero = (userDigitTEN != 4'd0) || (userDigitONE != 4'd0);
    if (!editSel) begin
      if (stepUp) begin
        editTen = incDigit(userDigitTEN, MAX_TEN_L);
      end else if (stepDown) begin
        editTen = decDigit(userDigitTEN, MAX_TEN_L);
      end
    end else begin
      if (stepUp) begin
        editOne = incDigit(userDigitONE, MAX_ONE_L);
      end else if (stepDown) begin
        editOne = decDigit(userDigitONE, MAX_ONE_L);
      end
    end
  end

  // Control FSM and every registered output; reset wins over all inputs,
  // including an in-flight reconfigure strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= EDIT;
      reconfCnt            <= 4'd0;
      userDigitTEN         <= 4'd0;
      userDigitONE         <= 4'd0;
      editSel              <= 1'b0;
      timerReconfigTEN_ONE <= 1'b1;
      enable               <= 1'b0;
      armed                <= 1'b0;
      expired              <= 1'b0;
    end else begin
      case (state)
        EDIT: begin
          // Commit outranks editing; a 00 value is not worth starting.
          if (btnCommit) begin
            if (digitsNonZero) begin
              state     <= RECONF;
              reconfCnt <= RECONF_L;
            end
          end else begin
            userDigitTEN <= editTen;
            userDigitONE <= editOne;
            if (btnSelect) begin
              editSel <= ~editSel;
            end
          end
        end
        RECONF: begin
          // Counter loaded at commit; each nonzero count holds the strobe low
          // for one more cycle, and the zero count releases it and arms.
          if (reconfCnt != 4'd0) begin
            timerReconfigTEN_ONE <= 1'b0;
            reconfCnt            <= reconfCnt - 4'd1;
          end else begin
            timerReconfigTEN_ONE <= 1'b1;
            enable               <= 1'b1;
            armed                <= 1'b1;
            state                <= ARMED;
          end
        end
        ARMED: begin
          if (timeOut) begin
            enable  <= 1'b0;
            armed   <= 1'b0;
            expired <= 1'b1;
            state   <= EXPIRED;
          end
        end
        EXPIRED: begin
          // Digits are kept so the same value can be restarted directly.
          if (btnCommit) begin
            expired <= 1'b0;
            editSel <= 1'b0;
            state   <= EDIT;
          end
        end
        default: begin
          state                <= EDIT;
          reconfCnt            <= 4'd0;
          userDigitTEN         <= 4'd0;
          userDigitONE         <= 4'd0;
          editSel              <= 1'b0;
          timerReconfigTEN_ONE <= 1'b1;
          enable               <= 1'b0;
          armed                <= 1'b0;
          expired              <= 1'b0;
        end
      endcase
    end
  end

endmodule
